jtframe_sdram_bank_arb: RTL and testbench

//  Merges BANKS game-side SDRAM bank clients (baN_* rd/wr handshakes) plus the ROM-download

---
 rtl/jtframe_sdram_pkg.sv | 21 ++
 rtl/jtframe_rr_pick.sv | 27 ++
 rtl/jtframe_sdram_bank_arb.sv | 203 ++++++++++++++++++++
 tb/tb_jtframe_sdram_bank_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_sdram_pkg.sv
// Shared types for the SDRAM bank arbiter: FSM states, client ids and the
// round-robin pointer update.
package jtframe_sdram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  typedef logic [1:0] bank_idx_t;
  typedef logic [2:0] client_t;

  // Client ids 0..3 are game banks; the download port sits above them
  localparam client_t PROG_ID = 3'd4;

  function automatic bank_idx_t next_ptr(input bank_idx_t g, input int banks);
    return (int'(g) >= banks - 1) ? 2'd0 : g + 2'd1;
  endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational 4-way picker: first pending request starting at ptr_i
// (round-robin) or at index 0 (fixed priority).
module jtframe_rr_pick (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  input  logic       rr_i,
  output logic [1:0] gnt_o,
  output logic       valid_o
);

  logic [1:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending one wins
  always_comb begin
    gnt_o   = 2'd0;
    valid_o = 1'b0;
    idx     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_i ? ptr_i + 2'(i) : 2'(i);
      if (req_i[idx]) begin
        gnt_o   = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtframe_sdram_bank_arb.sv
// Merges up to four game-side SDRAM bank clients and the ROM-download port
// onto one single-request SDRAM controller port, with a transfer watchdog.
module jtframe_sdram_bank_arb
  import jtframe_sdram_pkg::*;
#(
  parameter int SDRAMW = 22,
  parameter int BANKS  = 4,
  parameter int RR     = 1,
  parameter int TOUTW  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic [SDRAMW-1:0]     prog_addr,
  input  logic [1:0]            prog_ba,
  input  logic                  prog_we,
  input  logic                  prog_rd,
  input  logic [15:0]           prog_data,
  input  logic [1:0]            prog_mask,
  output logic                  prog_ack,
  output logic                  prog_dst,
  output logic                  prog_dok,
  output logic                  prog_rdy,
  input  logic [3:0]            ba_rd,
  input  logic [3:0]            ba_wr,
  input  logic [4*SDRAMW-1:0]   ba_addr,
  input  logic [63:0]           ba_din,
  input  logic [7:0]            ba_dsn,
  output logic [3:0]            ba_ack,
  output logic [3:0]            ba_dst,
  output logic [3:0]            ba_dok,
  output logic [3:0]            ba_rdy,
  output logic [SDRAMW-1:0]     sdr_addr,
  output logic [1:0]            sdr_ba,
  output logic                  sdr_rd,
  output logic                  sdr_wr,
  output logic [15:0]           sdr_din,
  output logic [1:0]            sdr_dsn,
  input  logic                  sdr_ack,
  input  logic                  sdr_dst,
  input  logic                  sdr_dok,
  input  logic                  sdr_rdy,
  output logic                  err_tout,
  output logic [1:0]            dbg_state,
  output logic [1:0]            dbg_ptr
);

  // Handshake: a client holds rd/wr as a level until its rdy pulse. The
  // controller request (sdr_rd/wr) is held until sdr_ack, then dropped; ack,
  // dst, dok and rdy are routed combinationally to the granted client only.

  localparam logic [3:0] BANK_MASK = 4'((1 << BANKS) - 1);

  arb_state_e          st_q, st_d;
  client_t             gnt_q, gnt_d;
  bank_idx_t           ptr_q, ptr_d;
  logic [TOUTW-1:0]    wd_q, wd_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic [SDRAMW-1:0]   addr_q, addr_d;
  logic [1:0]          ba_q, ba_d;
  logic [15:0]         din_q, din_d;
  logic [1:0]          dsn_q, dsn_d;

  logic [3:0]          pend;
  logic [1:0]          pick_gnt;
  logic                pick_valid;
  logic                advance, abort, is_prog;

  assign pend    = (ba_rd | ba_wr) & BANK_MASK;
  assign is_prog = (gnt_q == PROG_ID);
  assign advance = (st_q == REQ && sdr_ack) || (st_q == XFER && sdr_rdy);
  // A handshake arriving in the saturation cycle still completes normally
  assign abort   = (st_q != IDLE) && (wd_q == '1) && !advance;

  jtframe_rr_pick u_pick (
    .req_i   (pend),
    .ptr_i   (ptr_q),
    .rr_i    (RR != 0),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  always_comb begin
    st_d     = st_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    wd_d     = wd_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    ba_d     = ba_q;
    din_d    = din_q;
    dsn_d    = dsn_q;
    ba_ack   = 4'd0;
    ba_dst   = 4'd0;
    ba_dok   = 4'd0;
    ba_rdy   = 4'd0;
    prog_ack = 1'b0;
    prog_dst = 1'b0;
    prog_dok = 1'b0;
    prog_rdy = 1'b0;
    err_tout = 1'b0;
    case (st_q)
      IDLE: begin
        wd_d = '0;
        if (downloading) begin
          if (prog_we || prog_rd) begin
            st_d   = REQ;
            gnt_d  = PROG_ID;
            wr_d   = prog_we;
            rd_d   = ~prog_we;
            addr_d = prog_addr;
            ba_d   = prog_ba;
            din_d  = prog_data;
            dsn_d  = ~prog_mask;
          end
        end else if (pick_valid) begin
          st_d   = REQ;
          gnt_d  = {1'b0, pick_gnt};
          wr_d   = ba_wr[pick_gnt];
          rd_d   = ~ba_wr[pick_gnt];
          addr_d = ba_addr[pick_gnt*SDRAMW +: SDRAMW];
          ba_d   = pick_gnt;
          din_d  = ba_din[pick_gnt*16 +: 16];
          dsn_d  = ba_dsn[pick_gnt*2 +: 2];
        end
      end
      REQ: begin
        wd_d = wd_q + TOUTW'(1);
        if (is_prog) prog_ack = sdr_ack;
        else         ba_ack[gnt_q[1:0]] = sdr_ack;
        if (sdr_ack) begin
          st_d = XFER;
          rd_d = 1'b0;
          wr_d = 1'b0;
          wd_d = '0;
        end
      end
      XFER: begin
        wd_d = wd_q + TOUTW'(1);
        if (is_prog) begin
          prog_dst = sdr_dst;
          prog_dok = sdr_dok;
          prog_rdy = sdr_rdy;
        end else begin
          ba_dst[gnt_q[1:0]] = sdr_dst;
          ba_dok[gnt_q[1:0]] = sdr_dok;
          ba_rdy[gnt_q[1:0]] = sdr_rdy;
        end
        if (sdr_rdy) begin
          st_d = IDLE;
          wd_d = '0;
          if (!is_prog && RR != 0) ptr_d = next_ptr(gnt_q[1:0], BANKS);
        end
      end
      default: st_d = IDLE;
    endcase
    if (abort) begin
      st_d     = IDLE;
      rd_d     = 1'b0;
      wr_d     = 1'b0;
      wd_d     = '0;
      err_tout = 1'b1;
      if (!is_prog && RR != 0) ptr_d = next_ptr(gnt_q[1:0], BANKS);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      gnt_q  <= '0;
      ptr_q  <= '0;
      wd_q   <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      ba_q   <= '0;
      din_q  <= '0;
      dsn_q  <= 2'b11;
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      ptr_q  <= ptr_d;
      wd_q   <= wd_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      ba_q   <= ba_d;
      din_q  <= din_d;
      dsn_q  <= dsn_d;
    end
  end

  assign sdr_rd    = rd_q;
  assign sdr_wr    = wr_q;
  assign sdr_addr  = addr_q;
  assign sdr_ba    = ba_q;
  assign sdr_din   = din_q;
  assign sdr_dsn   = dsn_q;
  assign dbg_state = st_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_jtframe_sdram_bank_arb.sv
// Bench for jtframe_sdram_bank_arb: a round-robin instance and a fixed-priority
// instance share client stimulus; one controller model serves whichever is selected.
module tb_jtframe_sdram_bank_arb;

  localparam int SDRAMW = 22;
  localparam int EW     = 2 + 1 + 1 + SDRAMW + 16 + 2;

  localparam logic [SDRAMW-1:0] A0 = 22'h00_0100, A1 = 22'h01_1111,
                                A2 = 22'h02_2222, A3 = 22'h3F_3333;
  localparam logic [15:0] D0 = 16'hD000, D1 = 16'hD111, D2 = 16'hD222, D3 = 16'hD333;
  localparam logic [1:0]  M0 = 2'b01, M1 = 2'b10, M2 = 2'b00, M3 = 2'b01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_fp_n, sel;
  logic downloading;
  logic [SDRAMW-1:0] prog_addr;
  logic [1:0] prog_ba, prog_mask;
  logic prog_we, prog_rd;
  logic [15:0] prog_data;
  logic [3:0] ba_rd, ba_wr;
  logic [4*SDRAMW-1:0] ba_addr;
  logic [63:0] ba_din;
  logic [7:0] ba_dsn;
  logic ctl_ack, ctl_dst, ctl_dok, ctl_rdy;

  logic m_prog_ack, m_prog_dst, m_prog_dok, m_prog_rdy, m_rd, m_wr, m_err;
  logic [3:0] m_ba_ack, m_ba_dst, m_ba_dok, m_ba_rdy;
  logic [SDRAMW-1:0] m_addr;
  logic [1:0] m_ba, m_dsn, m_state, m_ptr;
  logic [15:0] m_din;
  logic f_prog_ack, f_prog_dst, f_prog_dok, f_prog_rdy, f_rd, f_wr, f_err;
  logic [3:0] f_ba_ack, f_ba_dst, f_ba_dok, f_ba_rdy;
  logic [SDRAMW-1:0] f_addr;
  logic [1:0] f_ba, f_dsn, f_state, f_ptr;
  logic [15:0] f_din;

  jtframe_sdram_bank_arb #(.SDRAMW(SDRAMW), .BANKS(4), .RR(1), .TOUTW(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_we(prog_we), .prog_rd(prog_rd),
    .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_ack(m_prog_ack), .prog_dst(m_prog_dst), .prog_dok(m_prog_dok), .prog_rdy(m_prog_rdy),
    .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_addr(ba_addr), .ba_din(ba_din), .ba_dsn(ba_dsn),
    .ba_ack(m_ba_ack), .ba_dst(m_ba_dst), .ba_dok(m_ba_dok), .ba_rdy(m_ba_rdy),
    .sdr_addr(m_addr), .sdr_ba(m_ba), .sdr_rd(m_rd), .sdr_wr(m_wr),
    .sdr_din(m_din), .sdr_dsn(m_dsn),
    .sdr_ack(sel ? 1'b0 : ctl_ack), .sdr_dst(sel ? 1'b0 : ctl_dst),
    .sdr_dok(sel ? 1'b0 : ctl_dok), .sdr_rdy(sel ? 1'b0 : ctl_rdy),
    .err_tout(m_err), .dbg_state(m_state), .dbg_ptr(m_ptr)
  );

  jtframe_sdram_bank_arb #(.SDRAMW(SDRAMW), .BANKS(4), .RR(0), .TOUTW(4)) u_dut_fp (
    .clk(clk), .rst_n(rst_fp_n), .downloading(downloading),
    .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_we(prog_we), .prog_rd(prog_rd),
    .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_ack(f_prog_ack), .prog_dst(f_prog_dst), .prog_dok(f_prog_dok), .prog_rdy(f_prog_rdy),
    .ba_rd(ba_rd), .ba_wr(ba_wr), .ba_addr(ba_addr), .ba_din(ba_din), .ba_dsn(ba_dsn),
    .ba_ack(f_ba_ack), .ba_dst(f_ba_dst), .ba_dok(f_ba_dok), .ba_rdy(f_ba_rdy),
    .sdr_addr(f_addr), .sdr_ba(f_ba), .sdr_rd(f_rd), .sdr_wr(f_wr),
    .sdr_din(f_din), .sdr_dsn(f_dsn),
    .sdr_ack(sel ? ctl_ack : 1'b0), .sdr_dst(sel ? ctl_dst : 1'b0),
    .sdr_dok(sel ? ctl_dok : 1'b0), .sdr_rdy(sel ? ctl_rdy : 1'b0),
    .err_tout(f_err), .dbg_state(f_state), .dbg_ptr(f_ptr)
  );

  logic mon_rd, mon_wr, mon_err, mon_prog_ack, mon_prog_rdy;
  logic [3:0] mon_ba_ack, mon_ba_rdy;
  logic [SDRAMW-1:0] mon_addr;
  logic [1:0] mon_ba, mon_dsn, mon_state, mon_ptr;
  logic [15:0] mon_din;
  assign mon_rd       = sel ? f_rd       : m_rd;
  assign mon_wr       = sel ? f_wr       : m_wr;
  assign mon_err      = sel ? f_err      : m_err;
  assign mon_prog_ack = sel ? f_prog_ack : m_prog_ack;
  assign mon_prog_rdy = sel ? f_prog_rdy : m_prog_rdy;
  assign mon_ba_ack   = sel ? f_ba_ack   : m_ba_ack;
  assign mon_ba_rdy   = sel ? f_ba_rdy   : m_ba_rdy;
  assign mon_addr     = sel ? f_addr     : m_addr;
  assign mon_ba       = sel ? f_ba       : m_ba;
  assign mon_dsn      = sel ? f_dsn      : m_dsn;
  assign mon_din      = sel ? f_din      : m_din;
  assign mon_state    = sel ? f_state    : m_state;
  assign mon_ptr      = sel ? f_ptr      : m_ptr;

  // ---------------- controller model ----------------
  int ack_dly = 3, rdy_dly = 6, cyc = 0;
  bit ack_en = 1'b1, rdy_en = 1'b1, in_flight = 1'b0;

  initial begin
    ctl_ack = 1'b0; ctl_dst = 1'b0; ctl_dok = 1'b0; ctl_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      ctl_ack = 1'b0; ctl_dst = 1'b0; ctl_dok = 1'b0; ctl_rdy = 1'b0;
      if (mon_state == 2'd0) in_flight = 1'b0;
      if (in_flight) begin
        cyc++;
        if (ack_en && cyc == ack_dly) ctl_ack = 1'b1;
        if (rdy_en && cyc == rdy_dly - 1) begin ctl_dst = 1'b1; ctl_dok = 1'b1; end
        if (rdy_en && cyc == rdy_dly) ctl_rdy = 1'b1;
      end else if (mon_rd || mon_wr) begin
        in_flight = 1'b1;
        cyc = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0, n_pass = 0;
  int ack_cnt[5], rdy_cnt[5];
  int err_cnt = 0, err_cyc = -1;
  bit prev_req = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [EW-1:0] mk(input logic [1:0] b, input logic wr, input logic rd,
                                       input logic [SDRAMW-1:0] a, input logic [15:0] d,
                                       input logic [1:0] m);
    return {b, wr, rd, a, d, m};
  endfunction

  always @(negedge clk) begin
    logic [EW-1:0] got;
    if ((mon_rd || mon_wr) && !prev_req) begin
      got = {mon_ba, mon_wr, mon_rd, mon_addr, mon_din, mon_dsn};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_req: got %0h, expected no request", got);
      end else begin
        check("sdr_request", 64'(got), 64'(exp_q.pop_front()));
      end
    end
    prev_req = mon_rd || mon_wr;
    for (int i = 0; i < 4; i++) begin
      ack_cnt[i] += int'(mon_ba_ack[i]);
      rdy_cnt[i] += int'(mon_ba_rdy[i]);
    end
    ack_cnt[4] += int'(mon_prog_ack);
    rdy_cnt[4] += int'(mon_prog_rdy);
    if (mon_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_cnt();
    for (int i = 0; i < 5; i++) begin ack_cnt[i] = 0; rdy_cnt[i] = 0; end
    err_cnt = 0;
    err_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge that ends the last rdy cycle, so the caller can
  // drop held requests before the arbiter's idle cycle samples them.
  task automatic wait_rdy(input int n, input int budget, input string name);
    int got = 0;
    int t = 0;
    while (got < n && t < budget) begin
      @(negedge clk);
      t++;
      if (|mon_ba_rdy || mon_prog_rdy) got++;
    end
    check({name, "_rdy_seen"}, 64'(got), 64'(n));
    @(posedge clk); #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int t = 0;
    while (mon_state != s && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({name, "_state_reached"}, 64'(mon_state), 64'(s));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    rst_n = 1'b0; rst_fp_n = 1'b0; sel = 1'b0; downloading = 1'b0;
    prog_addr = '0; prog_ba = '0; prog_mask = '0; prog_we = 1'b0; prog_rd = 1'b0;
    prog_data = '0; ba_rd = '0; ba_wr = '0;
    ba_addr = {A3, A2, A1, A0};
    ba_din  = {D3, D2, D1, D0};
    ba_dsn  = {M3, M2, M1, M0};
    clear_cnt();
    idle(3);

    check("rst_sdr_rd", 64'(m_rd), 0);
    check("rst_sdr_wr", 64'(m_wr), 0);
    check("rst_sdr_dsn", 64'(m_dsn), 64'(2'b11));
    check("rst_sdr_addr", 64'(m_addr), 0);
    check("rst_state", 64'(m_state), 0);
    check("rst_ptr", 64'(m_ptr), 0);
    check("rst_handshakes", 64'({m_ba_ack, m_ba_rdy, m_prog_ack, m_prog_rdy, m_err}), 0);
    rst_n = 1'b1;
    idle(2);

    // Round-robin over held banks 0,1,3
    clear_cnt();
    exp_q.push_back(mk(2'd0, 1'b0, 1'b1, A0, D0, M0));
    exp_q.push_back(mk(2'd1, 1'b0, 1'b1, A1, D1, M1));
    exp_q.push_back(mk(2'd3, 1'b0, 1'b1, A3, D3, M3));
    exp_q.push_back(mk(2'd0, 1'b0, 1'b1, A0, D0, M0));
    ba_rd = 4'b1011;
    wait_rdy(4, 200, "rr");
    ba_rd = 4'b0000;
    idle(4);
    check("rr_rdy_bank0", 64'(rdy_cnt[0]), 2);
    check("rr_rdy_bank1", 64'(rdy_cnt[1]), 1);
    check("rr_rdy_bank3", 64'(rdy_cnt[3]), 1);
    check("rr_ptr_after", 64'(m_ptr), 1);

    // Single read on bank 2, ack at +3, rdy at +6
    clear_cnt();
    exp_q.push_back(mk(2'd2, 1'b0, 1'b1, A2, D2, M2));
    ba_rd = 4'b0100;
    wait_rdy(1, 60, "single");
    ba_rd = 4'b0000;
    idle(3);
    check("single_ack2", 64'(ack_cnt[2]), 1);
    check("single_rdy2", 64'(rdy_cnt[2]), 1);
    check("single_other_ack", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[3] + ack_cnt[4]), 0);
    check("single_other_rdy", 64'(rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[3] + rdy_cnt[4]), 0);

    // Download exclusivity: prog write served, bank 1 held off
    clear_cnt();
    exp_q.push_back(mk(2'd3, 1'b1, 1'b0, 22'h1234, 16'hBEEF, 2'b10));
    downloading = 1'b1;
    ba_rd = 4'b0010;
    prog_addr = 22'h1234; prog_ba = 2'd3; prog_mask = 2'b01; prog_data = 16'hBEEF;
    prog_we = 1'b1;
    wait_rdy(1, 60, "dl_prog");
    prog_we = 1'b0;
    idle(8);
    check("dl_hold_idle", 64'(m_state), 0);
    check("dl_prog_ack", 64'(ack_cnt[4]), 1);
    check("dl_prog_rdy", 64'(rdy_cnt[4]), 1);
    check("dl_bank1_blocked", 64'(rdy_cnt[1] + ack_cnt[1]), 0);
    exp_q.push_back(mk(2'd1, 1'b0, 1'b1, A1, D1, M1));
    downloading = 1'b0;
    wait_rdy(1, 60, "dl_release");
    ba_rd = 4'b0000;
    idle(3);
    check("dl_bank1_rdy", 64'(rdy_cnt[1]), 1);

    // downloading rises while bank 0 is in XFER; client also drops early
    clear_cnt();
    exp_q.push_back(mk(2'd0, 1'b0, 1'b1, A0, D0, M0));
    exp_q.push_back(mk(2'd1, 1'b0, 1'b1, 22'h0ABC, 16'h1357, 2'b00));
    ba_rd = 4'b0001;
    wait_state(2'd2, 40, "mid_dl");
    @(posedge clk); #1;
    ba_rd = 4'b0000;
    downloading = 1'b1;
    prog_addr = 22'h0ABC; prog_ba = 2'd1; prog_mask = 2'b11; prog_data = 16'h1357;
    prog_rd = 1'b1;
    wait_rdy(2, 80, "mid_dl");
    prog_rd = 1'b0;
    downloading = 1'b0;
    idle(3);
    check("mid_dl_bank0_rdy", 64'(rdy_cnt[0]), 1);
    check("mid_dl_prog_rdy", 64'(rdy_cnt[4]), 1);

    // rd and wr together on bank 3 is a write
    clear_cnt();
    exp_q.push_back(mk(2'd3, 1'b1, 1'b0, A3, D3, M3));
    ba_rd = 4'b1000;
    ba_wr = 4'b1000;
    wait_rdy(1, 60, "rdwr");
    ba_rd = 4'b0000;
    ba_wr = 4'b0000;
    idle(3);
    check("rdwr_rdy3", 64'(rdy_cnt[3]), 1);
    check("ptr_before_wd", 64'(m_ptr), 0);

    // Watchdog: controller never answers
    clear_cnt();
    ack_en = 1'b0;
    rdy_en = 1'b0;
    exp_q.push_back(mk(2'd2, 1'b0, 1'b1, A2, D2, M2));
    ba_rd = 4'b0100;
    t = 0;
    while (!mon_err && t < 60) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    ba_rd = 4'b0000;
    check("wd_state_idle", 64'(m_state), 0);
    check("wd_sdr_rd_dropped", 64'(m_rd), 0);
    check("wd_err_cycle", 64'(err_cyc), 15);
    check("wd_ptr_advanced", 64'(m_ptr), 3);
    idle(4);
    check("wd_err_pulses", 64'(err_cnt), 1);
    check("wd_no_rdy", 64'(rdy_cnt[2]), 0);
    ack_en = 1'b1;

    // Reset during XFER
    clear_cnt();
    exp_q.push_back(mk(2'd0, 1'b0, 1'b1, A0, D0, M0));
    ba_rd = 4'b0001;
    wait_state(2'd2, 40, "rst_xfer");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rstx_state", 64'(m_state), 0);
    check("rstx_ptr", 64'(m_ptr), 0);
    check("rstx_sdr_rdwr", 64'({m_rd, m_wr}), 0);
    check("rstx_sdr_dsn", 64'(m_dsn), 64'(2'b11));
    check("rstx_handshakes", 64'({m_ba_ack, m_ba_rdy, m_err}), 0);
    ba_rd = 4'b0000;
    rdy_en = 1'b1;
    idle(2);

    // Fixed priority: bank 0 starves 1 and 3
    sel = 1'b1;
    rst_fp_n = 1'b1;
    idle(2);
    clear_cnt();
    repeat (3) exp_q.push_back(mk(2'd0, 1'b0, 1'b1, A0, D0, M0));
    ba_rd = 4'b1011;
    wait_rdy(3, 150, "fp");
    ba_rd = 4'b0000;
    idle(4);
    check("fp_rdy_bank0", 64'(rdy_cnt[0]), 3);
    check("fp_starved", 64'(rdy_cnt[1] + rdy_cnt[3]), 0);
    check("fp_ptr_unused", 64'(f_ptr), 0);

    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
